// File: rtl/timer_peripheral.sv
// rtl/timer_peripheral.sv - memory-mapped TH/TL/TCON timer with interrupt request and digit register
module timer_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        irq_out,
  output logic [11:0] digi
);

  localparam int unsigned   PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_TERM  = PW'(PRESCALE - 1);
  localparam logic [31:0]   OFF_TH   = 32'h00;
  localparam logic [31:0]   OFF_TL   = 32'h04;
  localparam logic [31:0]   OFF_TCON = 32'h08;
  localparam logic [31:0]   OFF_DIGI = 32'h14;

  logic [31:0]   th;
  logic [31:0]   tl;
  logic [2:0]    tcon;
  logic [11:0]   digi_r;
  logic [PW-1:0] ps_cnt;

  logic [31:0] off;
  logic        sel_th;
  logic        sel_tl;
  logic        sel_tcon;
  logic        sel_digi;
  logic        tick;
  logic        wrap;
  logic        status_set;

  // Word offset within the window; byte lane bits are dropped.
  assign off      = (addr - BASE_ADDR) & 32'hFFFF_FFFC;
  assign sel_th   = (off == OFF_TH);
  assign sel_tl   = (off == OFF_TL);
  assign sel_tcon = (off == OFF_TCON);
  assign sel_digi = (off == OFF_DIGI);

  assign tick       = tcon[0] && (ps_cnt == PS_TERM);
  assign wrap       = tick && (tl == 32'hFFFF_FFFF);
  assign status_set = wrap && tcon[1];

  always_comb begin
    rdata = '0;
    if (mem_read) begin
      if (sel_th)        rdata = th;
      else if (sel_tl)   rdata = tl;
      else if (sel_tcon) rdata = {29'd0, tcon};
      else if (sel_digi) rdata = {20'd0, digi_r};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      th     <= '0;
      tl     <= '0;
      tcon   <= '0;
      digi_r <= '0;
      ps_cnt <= '0;
    end else begin
      if (!tcon[0] || tick) ps_cnt <= '0;
      else                  ps_cnt <= ps_cnt + PW'(1);

      // A CPU store to TL overrides both the increment and the reload.
      if (mem_write && sel_tl) tl <= wdata;
      else if (tick)           tl <= wrap ? th : tl + 32'd1;

      if (mem_write && sel_th) th <= wdata;

      // Overflow status is OR'd into a same-edge TCON store so no interrupt is lost.
      if (mem_write && sel_tcon) tcon <= {wdata[2] | status_set, wdata[1:0]};
      else if (status_set)       tcon[2] <= 1'b1;

      if (mem_write && sel_digi) digi_r <= wdata[11:0];
    end
  end

  assign irq_out = tcon[1] & tcon[2];
  assign digi    = digi_r;

endmodule

// File: tb/tb_timer_peripheral.sv
// tb/tb_timer_peripheral.sv - randomized scoreboard bench for timer_peripheral
module tb_timer_peripheral;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;
  logic [11:0] digi1, digi4;

  always #5 clk = ~clk;

  timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(1)) u1 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_write(mem_write),
    .mem_read(mem_read), .rdata(rdata1), .irq_out(irq1), .digi(digi1)
  );

  timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(4)) u4 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_write(mem_write),
    .mem_read(mem_read), .rdata(rdata4), .irq_out(irq4), .digi(digi4)
  );

  typedef struct {
    bit          chk;
    logic [31:0] rd1;
    logic [31:0] rd4;
    logic        irq1;
    logic        irq4;
    logic [11:0] dg1;
    logic [11:0] dg4;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference state for both instances: index 0 -> PRESCALE 1, index 1 -> PRESCALE 4
  logic [31:0] m_th[2];
  logic [31:0] m_tl[2];
  logic [2:0]  m_tc[2];
  logic [11:0] m_dg[2];
  int          m_pc[2];
  bit          m_known = 1'b0;

  function automatic int ps(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] reg_off(input logic [31:0] a);
    return (a - BASE) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [31:0] a, input logic re);
    if (!re) return 32'd0;
    case (reg_off(a))
      32'h00:  return m_th[k];
      32'h04:  return m_tl[k];
      32'h08:  return {29'd0, m_tc[k]};
      32'h14:  return {20'd0, m_dg[k]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic rn, input logic [31:0] a, input logic [31:0] d, input logic we);
    for (int k = 0; k < 2; k++) begin
      logic        tick, wrap, st;
      logic [31:0] ntl, nth;
      logic [2:0]  ntc;
      logic [11:0] ndg;
      int          npc;
      if (!rn) begin
        m_th[k] = 0; m_tl[k] = 0; m_tc[k] = 0; m_dg[k] = 0; m_pc[k] = 0;
        m_known = 1'b1;
      end else begin
        tick = m_tc[k][0] && (m_pc[k] == ps(k) - 1);
        wrap = tick && (m_tl[k] == 32'hFFFF_FFFF);
        st   = wrap && m_tc[k][1];
        npc  = (m_tc[k][0] && !tick) ? m_pc[k] + 1 : 0;
        ntl  = tick ? (wrap ? m_th[k] : m_tl[k] + 1) : m_tl[k];
        nth  = m_th[k];
        ntc  = m_tc[k] | {st, 2'b00};
        ndg  = m_dg[k];
        if (we) begin
          case (reg_off(a))
            32'h00: nth = d;
            32'h04: ntl = d;
            32'h08: ntc = {d[2] | st, d[1:0]};
            32'h14: ndg = d[11:0];
            default: ;
          endcase
        end
        m_th[k] = nth; m_tl[k] = ntl; m_tc[k] = ntc; m_dg[k] = ndg; m_pc[k] = npc;
      end
    end
  endtask

  int   cycle     = 0;
  int   rises     = 0;
  int   last_rise = -1;
  logic prev_irq  = 1'b0;

  task automatic cyc(input logic rn, input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic re);
    exp_t e;
    reset = rn; addr = a; wdata = d; mem_write = we; mem_read = re;
    e.chk  = m_known;
    e.rd1  = m_read(0, a, re);
    e.rd4  = m_read(1, a, re);
    e.irq1 = m_tc[0][1] & m_tc[0][2];
    e.irq4 = m_tc[1][1] & m_tc[1][2];
    e.dg1  = m_dg[0];
    e.dg4  = m_dg[1];
    sbq.push_back(e);
    @(posedge clk);
    model_step(rn, a, d, we);
    #1;
    cycle++;
    if (irq1 && !prev_irq) begin
      rises++;
      last_rise = cycle;
    end
    prev_irq = irq1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    cyc(1'b1, a, $urandom, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rd(BASE + 32'h4);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      if (mon_e.chk) begin
        check("rdata_p1", rdata1, mon_e.rd1);
        check("rdata_p4", rdata4, mon_e.rd4);
        check("irq_p1", {31'd0, irq1}, {31'd0, mon_e.irq1});
        check("irq_p4", {31'd0, irq4}, {31'd0, mon_e.irq4});
        check("digi_p1", {20'd0, digi1}, {20'd0, mon_e.dg1});
        check("digi_p4", {20'd0, digi4}, {20'd0, mon_e.dg4});
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, r1, n;
    logic [31:0] offs [8];
    logic [31:0] a, d, o;
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h20};

    reset = 1'b0; addr = '0; wdata = '0; mem_write = 1'b0; mem_read = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++)
      cyc(1'b0, BASE + 32'($urandom_range(0, 7) * 4), $urandom,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    rd(BASE + 32'h00); rd(BASE + 32'h04); rd(BASE + 32'h08); rd(BASE + 32'h14);
    check("reset_irq", {31'd0, irq1}, 32'd0);
    check("reset_digi", {20'd0, digi1}, 32'd0);

    // Boot: TH = -30000, TL one tick from overflow
    wr(BASE + 32'h08, 32'd0);
    wr(BASE + 32'h00, 32'hFFFF8AD0);
    wr(BASE + 32'h04, 32'hFFFFFFFF);
    wr(BASE + 32'h08, 32'd3);
    rd(BASE + 32'h04);
    check("boot_irq", {31'd0, irq1}, 32'd1);
    r0 = last_rise;
    rd(BASE + 32'h08);
    wr(BASE + 32'h08, 32'd3);
    check("boot_clear_irq", {31'd0, irq1}, 32'd0);
    r1 = rises;
    n  = 0;
    while (rises == r1 && n < 31000) begin
      idle(1);
      n++;
    end
    check("irq_period", 32'(last_rise - r0), 32'd30000);

    // Handler clear of interrupt enable and status
    rd(BASE + 32'h08);
    wr(BASE + 32'h08, 32'd7 & 32'hFFFFFFF9);
    check("handler_irq_low", {31'd0, irq1}, 32'd0);
    idle(5);
    wr(BASE + 32'h08, 32'd3);
    idle(20);
    check("handler_irq_stays_low", {31'd0, irq1}, 32'd0);

    // TL store on the overflow edge
    wr(BASE + 32'h04, 32'hFFFFFFFF);
    wr(BASE + 32'h04, 32'd5);
    check("coll_tl_irq", {31'd0, irq1}, 32'd1);
    rd(BASE + 32'h04); rd(BASE + 32'h08);

    // TCON store on the overflow edge
    wr(BASE + 32'h08, 32'd3);
    wr(BASE + 32'h04, 32'hFFFFFFFF);
    wr(BASE + 32'h08, 32'd3);
    check("coll_tcon_irq", {31'd0, irq1}, 32'd1);
    rd(BASE + 32'h08);

    // Prescaled counting and disable freeze
    wr(BASE + 32'h08, 32'd0);
    wr(BASE + 32'h00, 32'hFFFFFFFC);
    wr(BASE + 32'h04, 32'hFFFFFFFC);
    wr(BASE + 32'h08, 32'd1);
    idle(16);
    rd(BASE + 32'h04);
    idle(3);
    wr(BASE + 32'h08, 32'd0);
    idle(10);

    // Decode and read/write overlap
    wr(BASE + 32'h14, 32'h10F);
    check("digi_write", {20'd0, digi1}, 32'h10F);
    rd(BASE + 32'h14);
    wr(BASE + 32'h10, 32'hFFFFFFFF);
    wr(BASE + 32'h20, 32'hFFFFFFFF);
    rd(BASE + 32'h10); rd(BASE + 32'h20); rd(BASE + 32'h14);
    cyc(1'b1, BASE + 32'h14, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, BASE + 32'h14, 32'h0AA, 1'b1, 1'b1);
    rd(BASE + 32'h16);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      o = offs[$urandom_range(0, 7)];
      a = ($urandom_range(0, 15) == 0) ? $urandom : BASE + o + 32'($urandom_range(0, 3));
      case (o)
        32'h00, 32'h04: d = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
        32'h08:         d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7)) | 32'd1;
        default:        d = $urandom;
      endcase
      cyc(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, a, d,
          ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
